// File: rtl/udma_smi_slave.sv
// udma_smi_slave: PHY-side clause-22 SMI/MDIO responder with a register port.
// Option: UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN accepts 1-bit preambles after a completed frame.
module udma_smi_slave #(
    parameter int SYNC_STAGES  = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        mdc_i,
    input  logic        mdi_i,
    output logic        mdo_o,
    output logic        md_oen_o,
    input  logic [4:0]  phy_addr_i,
    output logic [4:0]  reg_addr_o,
    output logic [15:0] reg_wdata_o,
    output logic        reg_we_o,
    output logic        reg_re_o,
    input  logic [15:0] reg_rdata_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);

    typedef enum logic [2:0] {
        ST_PREAMBLE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_SKIP
    } state_t;

    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdi_sync;
    logic                   mdc_prev;
    logic                   mdc_s;
    logic                   mdi_s;
    logic                   edge_e;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [3:0]    hdr_cnt_q, hdr_cnt_d;
    logic [12:0]   hdr_q, hdr_d;
    logic [13:0]   hdr_full;
    logic          hdr_bad;
    logic          rd_q, rd_d;
    logic          ta_q, ta_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [14:0]   wsr_q, wsr_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          re_dly_q;
    logic          sof_ok;
    logic          mdo_d;
    logic          oen_d;
    logic [4:0]    addr_d;
    logic [15:0]   wdata_d;
    logic          we_d;
    logic          re_d;
    logic          busy_d;
    logic          err_d;
`ifdef UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN
    logic          supp_q, supp_d;
`endif

    assign mdc_s    = mdc_sync[SYNC_STAGES-1];
    assign mdi_s    = mdi_sync[SYNC_STAGES-1];
    assign edge_e   = mdc_s & ~mdc_prev;
    assign hdr_full = {hdr_q, mdi_s};
    assign hdr_bad  = (hdr_full[13:12] != 2'b01) ||
                      (hdr_full[11:10] == 2'b00) ||
                      (hdr_full[11:10] == 2'b11);

`ifdef UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN
    assign sof_ok = (pre_cnt_q == PRE_MAX) || (supp_q && (pre_cnt_q != '0));
`else
    assign sof_ok = (pre_cnt_q == PRE_MAX);
`endif

    // Bring MDC/MDIO into clk_i and remember MDC for rising-edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mdc_sync <= '0;
            mdi_sync <= '0;
            mdc_prev <= 1'b0;
        end else begin
            mdc_sync <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
            mdi_sync <= {mdi_sync[SYNC_STAGES-2:0], mdi_i};
            mdc_prev <= mdc_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_PREAMBLE;
            pre_cnt_q   <= '0;
            hdr_cnt_q   <= '0;
            hdr_q       <= '0;
            rd_q        <= 1'b0;
            ta_q        <= 1'b0;
            cnt_q       <= '0;
            wsr_q       <= '0;
            rdata_q     <= '0;
            re_dly_q    <= 1'b0;
            mdo_o       <= 1'b0;
            md_oen_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
`ifdef UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN
            supp_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            hdr_cnt_q   <= hdr_cnt_d;
            hdr_q       <= hdr_d;
            rd_q        <= rd_d;
            ta_q        <= ta_d;
            cnt_q       <= cnt_d;
            wsr_q       <= wsr_d;
            rdata_q     <= rdata_d;
            re_dly_q    <= reg_re_o;
            mdo_o       <= mdo_d;
            md_oen_o    <= oen_d;
            reg_addr_o  <= addr_d;
            reg_wdata_o <= wdata_d;
            reg_we_o    <= we_d;
            reg_re_o    <= re_d;
            busy_o      <= busy_d;
            err_o       <= err_d;
`ifdef UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN
            supp_q      <= supp_d;
`endif
        end
    end

    // Frame decoder: every decision is taken on an MDC rising edge.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        hdr_cnt_d = hdr_cnt_q;
        hdr_d     = hdr_q;
        rd_d      = rd_q;
        ta_d      = ta_q;
        cnt_d     = cnt_q;
        wsr_d     = wsr_q;
        rdata_d   = re_dly_q ? reg_rdata_i : rdata_q;
        mdo_d     = mdo_o;
        oen_d     = md_oen_o;
        addr_d    = reg_addr_o;
        wdata_d   = reg_wdata_o;
        we_d      = 1'b0;
        re_d      = 1'b0;
        busy_d    = busy_o;
        err_d     = 1'b0;
`ifdef UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN
        supp_d    = supp_q;
`endif
        if (edge_e) begin
            unique case (state_q)
                ST_PREAMBLE: begin
                    if (mdi_s) begin
                        if (pre_cnt_q != PRE_MAX) begin
                            pre_cnt_d = pre_cnt_q + PW'(1);
                        end
                    end else if (sof_ok) begin
                        hdr_d     = '0;
                        hdr_cnt_d = 4'd1;
                        busy_d    = 1'b1;
                        state_d   = ST_HDR;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
                ST_HDR: begin
                    hdr_d     = {hdr_q[11:0], mdi_s};
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q == 4'd13) begin
                        cnt_d = '0;
                        ta_d  = 1'b0;
                        if (hdr_bad) begin
                            err_d   = 1'b1;
                            state_d = ST_SKIP;
`ifdef UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN
                            supp_d  = 1'b0;
`endif
                        end else if (hdr_full[9:5] != phy_addr_i) begin
                            state_d = ST_SKIP;
`ifdef UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN
                            supp_d  = 1'b0;
`endif
                        end else begin
                            addr_d  = hdr_full[4:0];
                            rd_d    = hdr_full[11];
                            re_d    = hdr_full[11];
                            state_d = ST_TA;
                        end
                    end
                end
                ST_TA: begin
                    if (!ta_q) begin
                        ta_d = 1'b1;
                        if (rd_q) begin
                            oen_d = 1'b1;
                            mdo_d = 1'b0;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                        if (rd_q) begin
                            mdo_d = rdata_q[15];
                        end
                    end
                end
                ST_DATA: begin
                    cnt_d = cnt_q + 5'd1;
                    if (!rd_q) begin
                        wsr_d = {wsr_q[13:0], mdi_s};
                    end
                    if (cnt_q == 5'd15) begin
                        if (rd_q) begin
                            oen_d = 1'b0;
                            mdo_d = 1'b0;
                        end else begin
                            wdata_d = {wsr_q, mdi_s};
                            we_d    = 1'b1;
                        end
                        busy_d    = 1'b0;
                        pre_cnt_d = '0;
                        state_d   = ST_PREAMBLE;
`ifdef UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN
                        supp_d    = 1'b1;
`endif
                    end else if (rd_q) begin
                        mdo_d = rdata_q[4'd14 - cnt_q[3:0]];
                    end
                end
                ST_SKIP: begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd17) begin
                        busy_d    = 1'b0;
                        pre_cnt_d = '0;
                        state_d   = ST_PREAMBLE;
                    end
                end
                default: begin
                    state_d = ST_PREAMBLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udma_smi_slave.sv
// tb_udma_smi_slave: randomized MDIO master against a frame-level model.
// Follows UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN the same way as the design.
module tb_udma_smi_slave;

    localparam int SYNC    = 2;
    localparam int PRE_LEN = 32;
`ifdef UDMA_SMI_SLV_PREAMBLE_SUPPRESS_EN
    localparam bit SUPP = 1'b1;
`else
    localparam bit SUPP = 1'b0;
`endif
    localparam int K_REJ  = 0;
    localparam int K_ERR  = 1;
    localparam int K_SKIP = 2;
    localparam int K_RD   = 3;
    localparam int K_WR   = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        mdc_i;
    logic        mdi_i;
    logic        mdo_o;
    logic        md_oen_o;
    logic [4:0]  phy_addr_i;
    logic [4:0]  reg_addr_o;
    logic [15:0] reg_wdata_o;
    logic        reg_we_o;
    logic        reg_re_o;
    logic [15:0] reg_rdata_i;
    logic        busy_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    udma_smi_slave #(
        .SYNC_STAGES  (SYNC),
        .PREAMBLE_LEN (PRE_LEN)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .mdc_i       (mdc_i),
        .mdi_i       (mdi_i),
        .mdo_o       (mdo_o),
        .md_oen_o    (md_oen_o),
        .phy_addr_i  (phy_addr_i),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          we_cnt = 0;
    int          re_cnt = 0;
    int          err_cnt = 0;
    logic [4:0]  cap_waddr = '0;
    logic [4:0]  cap_raddr = '0;
    logic [15:0] cap_wdata = '0;
    logic        we_prev = 1'b0;
    logic        re_prev = 1'b0;
    logic        err_prev = 1'b0;
    bit          oen_allow = 1'b0;
    bit          idle = 1'b0;
    logic [15:0] regs [32];
    bit          supp_m = 1'b0;
    logic [4:0]  addr_m = '0;
    int          h = 5;
    logic [15:0] last_rword = '0;
    logic [4:0]  resp_addr;
    int          base;
    int          pre_r;
    logic [1:0]  sof_r;
    logic [1:0]  op_r;
    logic [4:0]  phy_r;
    logic [4:0]  ra_r;
    logic [15:0] wd_r;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle checks of bus ownership, strobe rules and idle state.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            chk("we_re_excl", 32'(reg_we_o & reg_re_o), 0);
            chk("oen_window", 32'(md_oen_o & ~oen_allow), 0);
            chk("mdo_released", 32'(mdo_o & ~md_oen_o), 0);
            chk("strobe_width", 32'((reg_we_o & we_prev) | (reg_re_o & re_prev) |
                                    (err_o & err_prev)), 0);
            if (idle) chk("busy_idle", 32'(busy_o), 0);
            if (reg_we_o) begin
                we_cnt++;
                cap_waddr = reg_addr_o;
                cap_wdata = reg_wdata_o;
            end
            if (reg_re_o) begin
                re_cnt++;
                cap_raddr = reg_addr_o;
            end
            if (err_o) err_cnt++;
        end
        we_prev  = reg_we_o;
        re_prev  = reg_re_o;
        err_prev = err_o;
    end

    // Register bank: read data valid only in the cycle after the strobe.
    initial begin
        reg_rdata_i = 16'h0;
        forever begin
            @(negedge clk_i);
            if (reg_re_o) begin
                resp_addr = reg_addr_o;
                @(posedge clk_i);
                #1 reg_rdata_i = regs[resp_addr];
                @(posedge clk_i);
                #1 reg_rdata_i = 16'($urandom);
            end
        end
    end

    task automatic mdc_bit(input logic b, output logic so, output logic sm,
                           output logic sb);
        mdi_i = b;
        repeat (h) @(posedge clk_i);
        #1;
        so    = md_oen_o;
        sm    = mdo_o;
        sb    = busy_o;
        mdc_i = 1'b1;
    endtask

    task automatic mdc_fall();
        repeat (h) @(posedge clk_i);
        #1 mdc_i = 1'b0;
    endtask

    task automatic send_frame(input int pre, input logic [1:0] sof,
                              input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] ra, input logic [15:0] wd,
                              input int stop_at);
        bit          q[$];
        logic [13:0] hdr;
        int          kind;
        int          ta1;
        int          last;
        int          drv;
        int          we0;
        int          re0;
        int          er0;
        logic        so;
        logic        sm;
        logic        sb;
        logic [15:0] rw;
        hdr = {sof, op, phy, ra};
        if (!((pre >= PRE_LEN) || (SUPP && supp_m && pre >= 1))) kind = K_REJ;
        else if (sof != 2'b01 || op == 2'b00 || op == 2'b11) kind = K_ERR;
        else if (phy != phy_addr_i) kind = K_SKIP;
        else if (op == 2'b10) kind = K_RD;
        else kind = K_WR;
        for (int i = 0; i < pre; i++) q.push_back(1'b1);
        for (int j = 13; j >= 0; j--) q.push_back(hdr[j]);
        if (op == 2'b10) begin
            for (int j = 0; j < 18; j++) q.push_back(1'b1);
        end else begin
            q.push_back(1'b1);
            q.push_back(1'b0);
            for (int j = 15; j >= 0; j--) q.push_back(wd[j]);
        end
        ta1  = pre + 14;
        last = pre + 31;
        drv  = 0;
        rw   = '0;
        we0  = we_cnt;
        re0  = re_cnt;
        er0  = err_cnt;
        idle = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            mdc_bit(q[i], so, sm, sb);
            if (kind == K_RD && i == ta1) begin
                chk("ta1_released", 32'(so), 0);
                oen_allow = 1'b1;
            end
            if (kind == K_RD && i > ta1) begin
                drv += int'(so);
                if (i == ta1 + 1) chk("ta2_zero", 32'(sm), 0);
                else rw = {rw[14:0], sm};
            end
            if (i == last) chk("busy_last", 32'(sb), 32'(kind != K_REJ));
            mdc_fall();
            if (i == stop_at) return;
        end
        mdc_bit(1'b0, so, sm, sb);
        mdc_fall();
        repeat (2) @(posedge clk_i);
        #1;
        oen_allow = 1'b0;
        idle      = 1'b1;
        chk("we_count", we_cnt - we0, 32'(kind == K_WR));
        chk("re_count", re_cnt - re0, 32'(kind == K_RD));
        chk("err_count", err_cnt - er0, 32'(kind == K_ERR));
        if (kind == K_WR) begin
            chk("waddr", 32'(cap_waddr), 32'(ra));
            chk("wdata", 32'(cap_wdata), 32'(wd));
            regs[ra] = wd;
            addr_m   = ra;
        end
        if (kind == K_RD) begin
            chk("raddr", 32'(cap_raddr), 32'(ra));
            chk("rd_driven", drv, 17);
            chk("rdata", 32'(rw), 32'(regs[ra]));
            addr_m     = ra;
            last_rword = rw;
        end
        chk("reg_addr", 32'(reg_addr_o), 32'(addr_m));
        chk("oen_end", 32'(md_oen_o), 0);
        if (kind == K_RD || kind == K_WR) supp_m = 1'b1;
        else if (kind == K_ERR || kind == K_SKIP) supp_m = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i     = 1'b0;
        mdc_i      = 1'b0;
        mdi_i      = 1'b0;
        phy_addr_i = 5'h01;
        for (int i = 0; i < 32; i++) regs[i] = 16'($urandom);
        regs[31] = 16'h1234;
        repeat (4) @(posedge clk_i);
        #1;
        chk("rst_mdo", 32'(mdo_o), 0);
        chk("rst_oen", 32'(md_oen_o), 0);
        chk("rst_addr", 32'(reg_addr_o), 0);
        chk("rst_wdata", 32'(reg_wdata_o), 0);
        chk("rst_we", 32'(reg_we_o), 0);
        chk("rst_re", 32'(reg_re_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_o), 0);
        rstn_i = 1'b1;
        idle   = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        send_frame(32, 2'b01, 2'b01, 5'h01, 5'h05, 16'hA5C3, -1);
        chk("lit_wdata", 32'(cap_wdata), 32'h0000A5C3);
        chk("lit_waddr", 32'(reg_addr_o), 32'h05);
        chk("lit_we_total", we_cnt, 1);

        send_frame(32, 2'b01, 2'b10, 5'h01, 5'h1F, 16'h0, -1);
        chk("lit_rword", 32'(last_rword), 32'h00001234);
        chk("lit_re_total", re_cnt, 1);

        send_frame(32, 2'b01, 2'b10, 5'h02, 5'h09, 16'h0, -1);
        chk("lit_skip_re", re_cnt, 1);
        chk("lit_skip_err", err_cnt, 0);
        send_frame(32, 2'b01, 2'b01, 5'h01, 5'h0C, 16'h0F0F, -1);
        chk("lit_after_skip", we_cnt, 2);

        send_frame(32, 2'b01, 2'b11, 5'h01, 5'h04, 16'hFFFF, -1);
        chk("lit_err_total", err_cnt, 1);
        send_frame(32, 2'b01, 2'b01, 5'h01, 5'h06, 16'h3C3C, -1);
        chk("lit_after_err", we_cnt, 3);

        base = we_cnt;
        send_frame(1, 2'b01, 2'b01, 5'h01, 5'h07, 16'h5A5A, -1);
        chk("lit_b2b", we_cnt - base, SUPP ? 1 : 0);

        for (int f = 0; f < 40; f++) begin
            h     = $urandom_range(4, 6);
            pre_r = ($urandom_range(0, 9) < 6) ? PRE_LEN + $urandom_range(0, 4)
                                                : $urandom_range(1, PRE_LEN - 1);
            sof_r = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
            op_r  = 2'($urandom_range(0, 3));
            phy_r = ($urandom_range(0, 4) == 0) ? 5'($urandom) : phy_addr_i;
            ra_r  = 5'($urandom);
            wd_r  = 16'($urandom);
            send_frame(pre_r, sof_r, op_r, phy_r, ra_r, wd_r, -1);
        end
        h = 5;

        send_frame(32, 2'b01, 2'b10, 5'h01, 5'h0A, 16'h0, 32 + 16 + 8);
        chk("oen_before_reset", 32'(md_oen_o), 1);
        rstn_i = 1'b0;
        #1;
        chk("arst_oen", 32'(md_oen_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_mdo", 32'(mdo_o), 0);
        mdc_i     = 1'b0;
        mdi_i     = 1'b0;
        oen_allow = 1'b0;
        supp_m    = 1'b0;
        addr_m    = '0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        idle = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        base = we_cnt;
        send_frame(31, 2'b01, 2'b01, 5'h01, 5'h03, 16'hBEEF, -1);
        chk("lit_pre31", we_cnt - base, 0);
        send_frame(32, 2'b01, 2'b01, 5'h01, 5'h03, 16'h4321, -1);
        chk("lit_pre32", we_cnt - base, 1);
        chk("lit_pre32_data", 32'(cap_wdata), 32'h00004321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
